fetch_unit: RTL

- IF stage of the MIPS pipeline.
- Owns the PC register and issues single-outstanding requests on the SRAM-like instruction bus.
- Latches fetched words into the ftod pipeline register that feeds decode.
- Consumes the next-PC and delay-slot indications that decode computes each cycle, closing the IF/ID loop from the producer side.

---
 rtl/cpu_defs.sv | 38 +++
 rtl/fetch_unit.sv | 124 ++++++++++++
 2 files changed

// File: rtl/cpu_defs.sv
// Shared CPU definitions: IF/ID pipeline register layout, fetch FSM states,
// and the reset/bubble constants used by the fetch stage.
package cpu_defs;

    localparam logic [31:0] CPU_RESET_PC     = 32'hBFC0_0000;
    localparam logic [31:0] CPU_BUBBLE_INSTR = 32'h0000_0000;

    // Fetch FSM states. S_DROP absorbs the data beat of a flushed request.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } fetch_state_e;

    // IF/ID pipeline register.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pcplus4;
        logic [31:0] instr;
        logic        addr_err_if;
        logic        in_delay_slot;
        logic        is_instr;
        logic        tlb_exc_if;
    } dp_ftod;

    // Empty slot: no instruction, no flags, zero pc fields.
    localparam dp_ftod FTOD_BUBBLE = '{
        pc:            32'h0,
        pcplus4:       32'h0,
        instr:         CPU_BUBBLE_INSTR,
        addr_err_if:   1'b0,
        in_delay_slot: 1'b0,
        is_instr:      1'b0,
        tlb_exc_if:    1'b0
    };

endpackage

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, issues single-outstanding requests on the
// SRAM-like instruction bus and fills the ftod register feeding decode.
//
// Handshake: a request is accepted on a cycle with inst_req & inst_addr_ok;
// its word returns on the first later-or-same cycle with inst_data_ok. At
// most one request is outstanding. Handoff to decode happens on a cycle
// where a word is ready, d_stall is low and flush is low.
module fetch_unit
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC     = CPU_RESET_PC,
    parameter logic [31:0] BUBBLE_INSTR = CPU_BUBBLE_INSTR
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [31:0]  f_nextpc,
    input  logic         f_indelayslot,
    input  logic         d_stall,
    input  logic         flush,
    input  logic [31:0]  flush_pc,
    output logic         inst_req,
    output logic [31:0]  inst_addr,
    input  logic         inst_addr_ok,
    input  logic         inst_data_ok,
    input  logic [31:0]  inst_rdata,
    output logic [31:0]  f_nowpc,
    output logic [31:0]  f_pcplus4,
    output dp_ftod       ftod,
    output fetch_state_e dbg_state
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_buf_q, instr_buf_d;
    dp_ftod       ftod_q, ftod_d;
    dp_ftod       bubble;

    logic         addr_err;
    logic         ready;
    logic [31:0]  instr_sel;

    assign addr_err  = (pc_q[1:0] != 2'b00);
    // Misaligned pc never goes to the bus; held low while in reset.
    assign inst_req  = resetn && (state_q == S_REQ) && !addr_err;
    assign inst_addr = pc_q;
    assign f_nowpc   = pc_q;
    assign f_pcplus4 = pc_q + 32'd4;
    assign ftod      = ftod_q;
    assign dbg_state = state_q;

    // A word is available this cycle: parked, arriving now, or an address-error slot.
    assign ready = (state_q == S_HOLD)
                 | ((state_q == S_WAIT) & inst_data_ok)
                 | (inst_req & inst_addr_ok & inst_data_ok)
                 | ((state_q == S_REQ) & addr_err);

    // Parked word, else error bubble, else the bus data on its data_ok cycle.
    assign instr_sel = (state_q == S_HOLD) ? instr_buf_q :
                       addr_err            ? BUBBLE_INSTR : inst_rdata;

    // Next-state, pc, parking buffer and ftod; flush has top priority.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_buf_d  = instr_buf_q;
        ftod_d       = ftod_q;
        bubble       = FTOD_BUBBLE;
        bubble.instr = BUBBLE_INSTR;

        if (flush) begin
            ftod_d = bubble;
            pc_d   = flush_pc;
            unique case (state_q)
                S_REQ:   state_d = (inst_req & inst_addr_ok & ~inst_data_ok) ? S_DROP : S_REQ;
                S_WAIT:  state_d = inst_data_ok ? S_REQ : S_DROP;
                S_HOLD:  state_d = S_REQ;
                S_DROP:  state_d = inst_data_ok ? S_REQ : S_DROP;
                default: state_d = S_REQ;
            endcase
        end else if (ready) begin
            if (!d_stall) begin
                ftod_d.pc            = pc_q;
                ftod_d.pcplus4       = pc_q + 32'd4;
                ftod_d.instr         = instr_sel;
                ftod_d.addr_err_if   = addr_err;
                ftod_d.in_delay_slot = f_indelayslot;
                ftod_d.is_instr      = 1'b1;
                ftod_d.tlb_exc_if    = 1'b0;
                pc_d                 = f_nextpc;
                state_d              = S_REQ;
            end else begin
                // Decode busy: park the word until it can be handed off.
                instr_buf_d = instr_sel;
                state_d     = S_HOLD;
            end
        end else begin
            if (!d_stall) begin
                ftod_d = bubble;
            end
            unique case (state_q)
                S_REQ:   if (inst_req & inst_addr_ok) state_d = S_WAIT;
                S_DROP:  if (inst_data_ok) state_d = S_REQ;
                default: state_d = state_q;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q             <= S_REQ;
            pc_q                <= RESET_PC;
            instr_buf_q         <= BUBBLE_INSTR;
            ftod_q              <= FTOD_BUBBLE;
            ftod_q.instr        <= BUBBLE_INSTR;
        end else begin
            state_q             <= state_d;
            pc_q                <= pc_d;
            instr_buf_q         <= instr_buf_d;
            ftod_q              <= ftod_d;
        end
    end

endmodule
